// File: rtl/seg7_scan4_pkg.sv
// Shared constants and types for the 4-digit multiplexed seven-segment driver.
package seg7_scan4_pkg;

  // All segments dark (active-low pattern).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex glyph table, {g,f,e,d,c,b,a} active-low; index 0 is the rightmost entry.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_scan4_hex_lut.sv
// Combinational nibble to seven-segment (active-low) decoder.
module seg7_hex_lut
  import seg7_scan4_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Straight table lookup; every nibble value has a glyph.
  always_comb begin
    seg_o = HEX_SEG[nib_i];
  end

endmodule

// File: rtl/seg7_scan4.sv
// Time-multiplexed 4-digit common-anode display driver with anti-ghost
// blanking, optional leading-zero suppression and frame-synchronous update.
module seg7_scan4
  import seg7_scan4_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        value_valid,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0] seg,
  output logic        dp
);

  localparam int TICK_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(REFRESH_DIV - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  digit_idx_t        digit_q, digit_d;
  logic [15:0]       shadow_q, shadow_d;
  logic [15:0]       active_q, active_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              tick_wrap;
  logic              frame_end;
  logic              in_blank;
  logic              lead_zero;
  logic [3:0]        cur_nib;
  logic [6:0]        cur_glyph;

  assign tick_wrap = (tick_q == TICK_MAX);
  assign frame_end = tick_wrap && (digit_q == 2'd3);
  assign in_blank  = (int'(tick_q) < BLANK_CYCLES);
  assign cur_nib   = active_q[{digit_q, 2'b00} +: 4];

  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 always shows so a zero value still reads "0".
  assign lead_zero = blank_lz && (digit_q != 2'd0) &&
                     ((active_q >> {digit_q, 2'b00}) == 16'h0000);

  seg7_hex_lut u_lut (
    .nib_i (cur_nib),
    .seg_o (cur_glyph)
  );

  // Scan counters and the shadow/active value pair; active only changes at
  // the 3->0 frame boundary so a frame never mixes two values.
  always_comb begin
    tick_d   = tick_wrap ? '0 : tick_q + 1'b1;
    digit_d  = tick_wrap ? digit_idx_t'(digit_q + 2'd1) : digit_q;
    shadow_d = value_valid ? value : shadow_q;
    active_d = active_q;
    if (frame_end) begin
      active_d = value_valid ? value : shadow_q;
    end
  end

  // Output pattern for the current scan position, registered one cycle later.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!in_blank) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = lead_zero ? SEG_OFF : cur_glyph;
      dp_d  = ~dp_in[digit_q];
    end
  end

  // State and output registers with synchronous reset to a dark display.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q   <= '0;
      digit_q  <= 2'd0;
      shadow_q <= 16'h0000;
      active_q <= 16'h0000;
      an_q     <= 4'b1111;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      tick_q   <= tick_d;
      digit_q  <= digit_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Self-checking bench for seg7_scan4 with a cycle-count based reference model.
module tb_seg7_scan4;

  localparam int RD = 4;
  localparam int BC = 1;
  localparam int FR = 4 * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vv  = 1'b0;
  logic        blz = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dpin  = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vec  = 0;
  int errs = 0;

  seg7_scan4 #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .value(value), .value_valid(vv),
    .dp_in(dpin), .blank_lz(blz), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: m_n counts cycles since reset release; slot position is
  // plain arithmetic on it. e_* is what the outputs must show after the edge.
  int          m_n = 0;
  int          m_t, m_d;
  logic [15:0] m_shadow = 16'h0, m_active = 16'h0;
  logic [3:0]  m_nib;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_shadow = 16'h0; m_active = 16'h0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      m_t   = m_n % RD;
      m_d   = (m_n / RD) % 4;
      m_nib = 4'(m_active >> (4 * m_d));
      if (m_t < BC) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(4'(1) << m_d);
        e_seg = (blz && m_d > 0 && (m_active >> (4 * m_d)) == 16'h0) ? 7'h7F : HEX[m_nib];
        e_dp  = ~dpin[m_d];
      end
      if (vv) m_shadow = value;
      if (m_n % FR == FR - 1) m_active = vv ? value : m_shadow;
      m_n++;
    end
  end

  // Anode invariant: all high or exactly one low, every cycle.
  always @(negedge clk) begin
    vec++;
    if (an !== 4'hF && !$onehot(~an)) begin
      errs++;
      $display("FAIL an_onehot an=%b at %0t", an, $time);
    end
  end

  task automatic test_reset();
    rst = 1'b1; vv = 1'b1; value = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        errs++;
        $display("FAIL reset_hold an=%b seg=%h dp=%b want 1111/7f/1", an, seg, dp);
      end
    end
    rst = 1'b0; vv = 1'b0; value = 16'h0000;
    @(negedge clk);
    vec++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errs++;
      $display("FAIL reset_first_blank an=%b seg=%h dp=%b want 1111/7f/1", an, seg, dp);
    end
    @(negedge clk);
    vec++;
    if ({an, seg, dp} !== {4'b1110, 7'h40, 1'b1}) begin
      errs++;
      $display("FAIL reset_digit0 an=%b seg=%h dp=%b want 1110/40/1", an, seg, dp);
    end
  endtask

  task automatic test_scan();
    logic [6:0] xs [4];
    logic [3:0] x_an; logic [6:0] x_seg;
    int g;
    xs = '{7'h19, 7'h30, 7'h24, 7'h79};
    vv = 1'b1; value = 16'h1234;
    @(negedge clk);
    vv = 1'b0;
    g = 0;
    while (m_n % FR != 0 && g < 64) begin @(negedge clk); g++; end
    if (g >= 64) begin errs++; $display("FAIL scan_align timeout n=%0d want boundary", m_n); end
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      x_an  = (i % RD < BC) ? 4'hF  : ~(4'(1) << (i / RD));
      x_seg = (i % RD < BC) ? 7'h7F : xs[i / RD];
      vec++;
      if ({an, seg} !== {x_an, x_seg}) begin
        errs++;
        $display("FAIL scan cyc=%0d an=%b seg=%h want %b/%h", i, an, seg, x_an, x_seg);
      end
    end
  endtask

  task automatic test_tear_free();
    logic [6:0] xo [4];
    logic [6:0] xn [4];
    logic [3:0] x_an; logic [6:0] x_seg;
    int p, g;
    xo = '{7'h19, 7'h30, 7'h24, 7'h79};
    xn = '{7'h21, 7'h46, 7'h03, 7'h08};
    g = 0;
    while (m_n % FR != 5 && g < 64) begin @(negedge clk); g++; end
    if (g >= 64) begin errs++; $display("FAIL tear_align timeout n=%0d want 5", m_n); end
    vv = 1'b1; value = 16'hABCD;
    @(negedge clk);
    vv = 1'b0; value = 16'h5555;
    for (int k = 6; k < 2 * FR; k++) begin
      @(negedge clk);
      p     = k % FR;
      x_an  = (p % RD < BC) ? 4'hF  : ~(4'(1) << (p / RD));
      x_seg = (p % RD < BC) ? 7'h7F : ((k < FR) ? xo[p / RD] : xn[p / RD]);
      vec++;
      if ({an, seg} !== {x_an, x_seg}) begin
        errs++;
        $display("FAIL tear_free k=%0d an=%b seg=%h want %b/%h", k, an, seg, x_an, x_seg);
      end
    end
  endtask

  task automatic test_bypass();
    logic [6:0] xn [4];
    logic [3:0] x_an; logic [6:0] x_seg;
    int g;
    xn = '{7'h46, 7'h78, 7'h06, 7'h10};
    g = 0;
    while (m_n % FR != FR - 1 && g < 64) begin @(negedge clk); g++; end
    if (g >= 64) begin errs++; $display("FAIL bypass_align timeout n=%0d want 15", m_n); end
    vv = 1'b1; value = 16'h9E7C;
    @(negedge clk);
    vv = 1'b0; value = 16'h1111;
    vec++;
    if ({an, seg} !== {4'b0111, 7'h08}) begin
      errs++;
      $display("FAIL bypass_last_old an=%b seg=%h want 0111/08", an, seg);
    end
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      x_an  = (i % RD < BC) ? 4'hF  : ~(4'(1) << (i / RD));
      x_seg = (i % RD < BC) ? 7'h7F : xn[i / RD];
      vec++;
      if ({an, seg} !== {x_an, x_seg}) begin
        errs++;
        $display("FAIL bypass cyc=%0d an=%b seg=%h want %b/%h", i, an, seg, x_an, x_seg);
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [6:0] xa [4];
    logic [6:0] xb [4];
    logic [3:0] x_an; logic [6:0] x_seg; logic x_dp;
    int g;
    xa = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    xb = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    blz = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      g = 0;
      while (m_n % FR != FR - 1 && g < 64) begin @(negedge clk); g++; end
      if (g >= 64) begin errs++; $display("FAIL lz_align timeout n=%0d want 15", m_n); end
      vv = 1'b1; value = (pass == 0) ? 16'h0050 : 16'h0000;
      dpin = (pass == 0) ? 4'b0000 : 4'b1000;
      @(negedge clk);
      vv = 1'b0;
      for (int i = 0; i < FR; i++) begin
        @(negedge clk);
        x_an  = (i % RD < BC) ? 4'hF  : ~(4'(1) << (i / RD));
        x_seg = (i % RD < BC) ? 7'h7F : ((pass == 0) ? xa[i / RD] : xb[i / RD]);
        x_dp  = !((i % RD >= BC) && (i / RD == 3) && pass == 1);
        vec++;
        if ({an, seg, dp} !== {x_an, x_seg, x_dp}) begin
          errs++;
          $display("FAIL lead_zero pass=%0d cyc=%0d an=%b seg=%h dp=%b want %b/%h/%b",
                   pass, i, an, seg, dp, x_an, x_seg, x_dp);
        end
      end
    end
    dpin = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int g;
    g = 0;
    while (m_n % FR != 9 && g < 64) begin @(negedge clk); g++; end
    if (g >= 64) begin errs++; $display("FAIL rstmid_align timeout n=%0d want 9", m_n); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errs++;
      $display("FAIL reset_mid_off an=%b seg=%h dp=%b want 1111/7f/1", an, seg, dp);
    end
    @(negedge clk);
    vec++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errs++;
      $display("FAIL reset_mid_blank an=%b seg=%h dp=%b want 1111/7f/1", an, seg, dp);
    end
    @(negedge clk);
    vec++;
    if ({an, seg, dp} !== {4'b1110, 7'h40, 1'b1}) begin
      errs++;
      $display("FAIL reset_mid_digit0 an=%b seg=%h dp=%b want 1110/40/1", an, seg, dp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      vec++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        errs++;
        $display("FAIL random cyc=%0d an=%b seg=%h dp=%b want %b/%h/%b",
                 i, an, seg, dp, e_an, e_seg, e_dp);
      end
      value = 16'($urandom);
      if ($urandom_range(3) == 0) value = value & 16'h00FF;
      vv    = ($urandom_range(7) == 0);
      dpin  = 4'($urandom);
      if ($urandom_range(15) == 0) blz = ~blz;
    end
    vv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_bypass();
    test_leading_zeros();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
